ga_sync_int: RTL and testbench

- Gate Array sync and interrupt stage, directly downstream of the CRTC in the CPC core.
- Consumes raw CRTC HSYNC/VSYNC. Produces the shortened/delayed monitor syncs, the Z80 raster interrupt (every 52 lines, resynchronised by VSYNC), and the video mode latched at sync time for the pixel shifter.
- All sampling is at character rate (CLKEN, 1 MHz). Interrupt acknowledge and clear act at full clock rate.

---
 rtl/ga_sync_int.sv | 98 +++++++++
 tb/tb_ga_sync_int.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ga_sync_int.sv
// ga_sync_int: Gate Array monitor sync shaping, raster interrupt and mode latch; GA_CSYNC_EN adds the CSYNC output
module ga_sync_int #(
  parameter int HS_DELAY  = 2,
  parameter int HS_MAX    = 4,
  parameter int VS_DELAY  = 2,
  parameter int VS_LEN    = 4,
  parameter int INT_LINES = 52
) (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       CLKEN,
  input  logic       HSYNC_I,
  input  logic       VSYNC_I,
  input  logic       INT_ACK,
  input  logic       INT_CLR,
  input  logic       MODE_WR,
  input  logic [1:0] MODE_I,
  output logic       HSYNC_O,
  output logic       VSYNC_O,
  output logic       INT,
  output logic [1:0] MODE,
`ifdef GA_CSYNC_EN
  output logic       CSYNC,
`endif
  output logic [5:0] LINE_CNT
);
  localparam int VW = $clog2(VS_DELAY + 1);
  localparam int LW = $clog2(VS_LEN + 1);
  logic hs_r, vs_r, hs_low, ack_r;
  logic hs_rise, hs_run, line_ev, vs_rise, ack_rise, resync, start, wrap;
  logic hs_o_n, vs_o_n, int_n;
  logic [2:0] hs_cnt, hs_cnt_n;
  logic [1:0] pend_mode, mode_n;
  logic [5:0] base_cnt, line_cnt_n;
  logic [VW-1:0] vs_wait, vs_wait_n;
  logic [LW-1:0] vs_len, vs_len_n;
  // next state: hs_low blocks a fake rising edge while HSYNC_I is still high coming out of reset
  always_comb begin
    hs_rise = CLKEN & HSYNC_I & ~hs_r & hs_low;
    hs_run = CLKEN & HSYNC_I & hs_low & (hs_cnt != 3'd7);
    line_ev = CLKEN & ~HSYNC_I & hs_r;
    vs_rise = CLKEN & VSYNC_I & ~vs_r;
    ack_rise = INT_ACK & ~ack_r;
    hs_cnt_n = hs_rise ? 3'd0 : hs_run ? hs_cnt + 3'd1 : hs_cnt;
    hs_o_n = CLKEN ? (HSYNC_I & hs_low & (hs_cnt_n >= 3'(HS_DELAY)) & (hs_cnt_n < 3'(HS_DELAY + HS_MAX))) : HSYNC_O;
    mode_n = (hs_o_n & ~HSYNC_O) ? (MODE_WR ? MODE_I : pend_mode) : MODE;
    resync = line_ev & (vs_wait == VW'(1));
    start = resync & ~INT_CLR;
    wrap = line_ev & (LINE_CNT == 6'(INT_LINES - 1));
    base_cnt = ack_rise ? {1'b0, LINE_CNT[4:0]} : LINE_CNT;
    line_cnt_n = (INT_CLR | resync | wrap) ? 6'd0 : line_ev ? base_cnt + 6'd1 : base_cnt;
    int_n = INT_CLR ? 1'b0 : (resync ? LINE_CNT[5] : wrap) ? 1'b1 : ack_rise ? 1'b0 : INT;
    vs_wait_n = INT_CLR ? '0 : vs_rise ? VW'(VS_DELAY) : (line_ev & |vs_wait) ? vs_wait - VW'(1) : vs_wait;
    vs_len_n = vs_rise ? '0 : start ? LW'(VS_LEN) : (line_ev & |vs_len) ? vs_len - LW'(1) : vs_len;
    vs_o_n = vs_rise ? 1'b0 : start ? 1'b1 : (line_ev & (vs_len == LW'(1))) ? 1'b0 : VSYNC_O;
  end
  // state and registered outputs; reset drops every output immediately
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      hs_r <= 1'b0;
      vs_r <= 1'b0;
      hs_low <= 1'b0;
      ack_r <= 1'b0;
      hs_cnt <= 3'd0;
      pend_mode <= 2'd0;
      vs_wait <= '0;
      vs_len <= '0;
      HSYNC_O <= 1'b0;
      VSYNC_O <= 1'b0;
      INT <= 1'b0;
      MODE <= 2'd0;
      LINE_CNT <= 6'd0;
    end else begin
      ack_r <= INT_ACK;
      if (CLKEN) begin
        hs_r <= HSYNC_I;
        vs_r <= VSYNC_I;
        hs_low <= hs_low | ~HSYNC_I;
      end
      if (MODE_WR) pend_mode <= MODE_I;
      hs_cnt <= hs_cnt_n;
      vs_wait <= vs_wait_n;
      vs_len <= vs_len_n;
      HSYNC_O <= hs_o_n;
      VSYNC_O <= vs_o_n;
      INT <= int_n;
      MODE <= mode_n;
      LINE_CNT <= line_cnt_n;
    end
  end
`ifdef GA_CSYNC_EN
  // composite sync follows the next output values so it lines up with HSYNC_O/VSYNC_O
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) CSYNC <= 1'b0;
    else CSYNC <= hs_o_n ^ vs_o_n;
  end
`endif
endmodule

// File: tb/tb_ga_sync_int.sv
// tb_ga_sync_int: scoreboard bench for ga_sync_int sync shaping, raster interrupt, vsync resync and mode latch
module tb_ga_sync_int;
  localparam int HS_DELAY = 2;
  localparam int HS_MAX = 4;
  localparam int INT_LINES = 52;
  typedef struct packed { logic [5:0] cnt; logic irq; logic vs; } ln_t;
  logic CLOCK = 1'b0, nRESET = 1'b0, CLKEN = 1'b0, HSYNC_I = 1'b0, VSYNC_I = 1'b0;
  logic INT_ACK = 1'b0, INT_CLR = 1'b0, MODE_WR = 1'b0;
  logic [1:0] MODE_I = 2'd0;
  logic HSYNC_O, VSYNC_O, INT;
  logic [1:0] MODE;
  logic [5:0] LINE_CNT;
`ifdef GA_CSYNC_EN
  logic CSYNC;
`endif
  ln_t ln_exp[$];
  logic hs_exp[$], hs_obs[$];
  logic [1:0] md_exp[$], md_obs[$];
  int checks = 0, errors = 0;

  always #5 CLOCK = ~CLOCK;

  ga_sync_int dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .CLKEN(CLKEN), .HSYNC_I(HSYNC_I), .VSYNC_I(VSYNC_I),
    .INT_ACK(INT_ACK), .INT_CLR(INT_CLR), .MODE_WR(MODE_WR), .MODE_I(MODE_I),
    .HSYNC_O(HSYNC_O), .VSYNC_O(VSYNC_O), .INT(INT), .MODE(MODE),
`ifdef GA_CSYNC_EN
    .CSYNC(CSYNC),
`endif
    .LINE_CNT(LINE_CNT)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the summary line");
    $fatal(1);
  end

  function automatic ln_t ln(input int c, input logic i, input logic v);
    return {6'(c), i, v};
  endfunction

  // one character: four clocks, CLKEN on the last; returns at the negedge after that CLKEN
  task automatic chr(input bit wr = 1'b0, input bit clr = 1'b0);
    repeat (3) @(negedge CLOCK);
    CLKEN = 1'b1;
    MODE_WR = wr;
    INT_CLR = clr;
    @(negedge CLOCK);
    CLKEN = 1'b0;
    MODE_WR = 1'b0;
    INT_CLR = 1'b0;
  endtask

  task automatic drive_line(input int hw, input int len = 20, input int wr_at = -1, input int clr_at = -1);
    hs_obs.delete();
    md_obs.delete();
    for (int k = 0; k < len; k++) begin
      HSYNC_I = (k < hw);
      chr(k == wr_at, k == clr_at);
      hs_obs.push_back(HSYNC_O);
      md_obs.push_back(MODE);
    end
  endtask

  task automatic test_reset();
    nRESET = 1'b0;
    repeat (3) @(negedge CLOCK);
    checks++;
    if ({HSYNC_O, VSYNC_O, INT, MODE, LINE_CNT} !== 11'b0) begin
      errors++;
      $display("FAIL reset: hs=%b vs=%b int=%b mode=%0d cnt=%0d, want all 0", HSYNC_O, VSYNC_O, INT, MODE, LINE_CNT);
    end
    nRESET = 1'b1;
    repeat (2) chr();
  endtask

  task automatic test_lines();
    ln_t e;
    logic x, o;
    for (int i = 1; i <= 60; i++) begin
      ln_exp.push_back(ln(i % INT_LINES, i >= INT_LINES, 1'b0));
      for (int k = 0; k < 20; k++) hs_exp.push_back(k >= HS_DELAY && k < HS_DELAY + HS_MAX && k < 14);
      drive_line(14);
      e = ln_exp.pop_front();
      checks++;
      if ({LINE_CNT, INT, VSYNC_O} !== e) begin
        errors++;
        $display("FAIL lines[%0d]: cnt=%0d int=%b vs=%b, want cnt=%0d int=%b vs=%b", i, LINE_CNT, INT, VSYNC_O, e.cnt, e.irq, e.vs);
      end
      for (int k = 0; k < 20; k++) begin
        x = hs_exp.pop_front();
        o = hs_obs.pop_front();
        checks++;
        if (o !== x) begin
          errors++;
          $display("FAIL hsync_o line %0d char %0d: got %b want %b", i, k, o, x);
        end
      end
    end
  endtask

  task automatic test_int_ack();
    ln_t e;
    for (int i = 9; i <= 40; i++) ln_exp.push_back(ln(i, 1'b1, 1'b0));
    while (ln_exp.size() > 0) begin
      drive_line(14);
      e = ln_exp.pop_front();
      checks++;
      if ({LINE_CNT, INT, VSYNC_O} !== e) begin
        errors++;
        $display("FAIL ack_pre: cnt=%0d int=%b vs=%b, want cnt=%0d int=%b vs=%b", LINE_CNT, INT, VSYNC_O, e.cnt, e.irq, e.vs);
      end
    end
    INT_ACK = 1'b1;
    @(negedge CLOCK);
    checks++;
    if (INT !== 1'b0 || LINE_CNT !== 6'd8) begin
      errors++;
      $display("FAIL ack_at_40: int=%b cnt=%0d, want int=0 cnt=8", INT, LINE_CNT);
    end
    repeat (2) @(negedge CLOCK);
    INT_ACK = 1'b0;
    for (int i = 9; i <= 51; i++) ln_exp.push_back(ln(i, 1'b0, 1'b0));
    ln_exp.push_back(ln(0, 1'b1, 1'b0));
    while (ln_exp.size() > 0) begin
      drive_line(14);
      e = ln_exp.pop_front();
      checks++;
      if ({LINE_CNT, INT, VSYNC_O} !== e) begin
        errors++;
        $display("FAIL ack_post: cnt=%0d int=%b vs=%b, want cnt=%0d int=%b vs=%b", LINE_CNT, INT, VSYNC_O, e.cnt, e.irq, e.vs);
      end
    end
    INT_ACK = 1'b1;
    @(negedge CLOCK);
    INT_ACK = 1'b0;
    checks++;
    if (INT !== 1'b0 || LINE_CNT !== 6'd0) begin
      errors++;
      $display("FAIL ack_at_0: int=%b cnt=%0d, want int=0 cnt=0", INT, LINE_CNT);
    end
  endtask

  task automatic test_vsync();
    ln_t e;
    int j;
    for (int i = 1; i <= 35; i++) ln_exp.push_back(ln(i, 1'b0, 1'b0));
    ln_exp.push_back(ln(36, 1'b0, 1'b0));
    ln_exp.push_back(ln(0, 1'b1, 1'b1));
    for (int i = 1; i <= 3; i++) ln_exp.push_back(ln(i, 1'b1, 1'b1));
    ln_exp.push_back(ln(4, 1'b1, 1'b0));
    j = 0;
    while (ln_exp.size() > 0) begin
      VSYNC_I = (j >= 35 && j < 38);
      drive_line(14);
      e = ln_exp.pop_front();
      checks++;
      if ({LINE_CNT, INT, VSYNC_O} !== e) begin
        errors++;
        $display("FAIL vsync_35 line %0d: cnt=%0d int=%b vs=%b, want cnt=%0d int=%b vs=%b", j, LINE_CNT, INT, VSYNC_O, e.cnt, e.irq, e.vs);
      end
      j++;
    end
    INT_ACK = 1'b1;
    @(negedge CLOCK);
    INT_ACK = 1'b0;
    checks++;
    if (INT !== 1'b0 || LINE_CNT !== 6'd4) begin
      errors++;
      $display("FAIL vsync_ack: int=%b cnt=%0d, want int=0 cnt=4", INT, LINE_CNT);
    end
    for (int i = 5; i <= 21; i++) ln_exp.push_back(ln(i, 1'b0, 1'b0));
    ln_exp.push_back(ln(0, 1'b0, 1'b1));
    for (int i = 1; i <= 3; i++) ln_exp.push_back(ln(i, 1'b0, 1'b1));
    ln_exp.push_back(ln(4, 1'b0, 1'b0));
    j = 0;
    while (ln_exp.size() > 0) begin
      VSYNC_I = (j >= 16 && j < 19);
      drive_line(14);
      e = ln_exp.pop_front();
      checks++;
      if ({LINE_CNT, INT, VSYNC_O} !== e) begin
        errors++;
        $display("FAIL vsync_20 line %0d: cnt=%0d int=%b vs=%b, want cnt=%0d int=%b vs=%b", j, LINE_CNT, INT, VSYNC_O, e.cnt, e.irq, e.vs);
      end
      j++;
    end
  endtask

  task automatic test_mode();
    logic [1:0] x, o;
    MODE_I = 2'd2;
    MODE_WR = 1'b1;
    @(negedge CLOCK);
    MODE_WR = 1'b0;
    checks++;
    if (MODE !== 2'd0) begin
      errors++;
      $display("FAIL mode_early: got %0d want 0", MODE);
    end
    for (int k = 0; k < 20; k++) md_exp.push_back(k >= HS_DELAY ? 2'd2 : 2'd0);
    drive_line(14);
    for (int k = 0; k < 20; k++) begin
      x = md_exp.pop_front();
      o = md_obs.pop_front();
      checks++;
      if (o !== x) begin
        errors++;
        $display("FAIL mode_load char %0d: got %0d want %0d", k, o, x);
      end
    end
    MODE_I = 2'd3;
    for (int k = 0; k < 20; k++) md_exp.push_back(k >= HS_DELAY ? 2'd3 : 2'd2);
    drive_line(14, 20, HS_DELAY);
    for (int k = 0; k < 20; k++) begin
      x = md_exp.pop_front();
      o = md_obs.pop_front();
      checks++;
      if (o !== x) begin
        errors++;
        $display("FAIL mode_coincide char %0d: got %0d want %0d", k, o, x);
      end
    end
  endtask

  task automatic test_clr();
    ln_t e;
    logic x, o;
    for (int i = 7; i <= 51; i++) ln_exp.push_back(ln(i, 1'b0, 1'b0));
    while (ln_exp.size() > 0) begin
      drive_line(14);
      e = ln_exp.pop_front();
      checks++;
      if ({LINE_CNT, INT, VSYNC_O} !== e) begin
        errors++;
        $display("FAIL clr_pre: cnt=%0d int=%b vs=%b, want cnt=%0d int=%b vs=%b", LINE_CNT, INT, VSYNC_O, e.cnt, e.irq, e.vs);
      end
    end
    ln_exp.push_back(ln(0, 1'b0, 1'b0));
    drive_line(14, 20, -1, 14);
    e = ln_exp.pop_front();
    checks++;
    if ({LINE_CNT, INT, VSYNC_O} !== e) begin
      errors++;
      $display("FAIL clr_at_wrap: cnt=%0d int=%b, want cnt=%0d int=%b", LINE_CNT, INT, e.cnt, e.irq);
    end
    for (int w = 2; w <= 3; w++) begin
      for (int k = 0; k < 20; k++) hs_exp.push_back(k == HS_DELAY && k < w);
      drive_line(w);
      for (int k = 0; k < 20; k++) begin
        x = hs_exp.pop_front();
        o = hs_obs.pop_front();
        checks++;
        if (o !== x) begin
          errors++;
          $display("FAIL hsync_width%0d char %0d: got %b want %b", w, k, o, x);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic x, o;
    VSYNC_I = 1'b1;
    repeat (2) drive_line(14);
    VSYNC_I = 1'b0;
    checks++;
    if ({HSYNC_O, VSYNC_O} !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset_vs: hs=%b vs=%b, want hs=0 vs=1", HSYNC_O, VSYNC_O);
    end
`ifdef GA_CSYNC_EN
    checks++;
    if (CSYNC !== 1'b1) begin
      errors++;
      $display("FAIL csync_vs_only: got %b want 1", CSYNC);
    end
`endif
    HSYNC_I = 1'b1;
    repeat (3) chr();
    checks++;
    if ({HSYNC_O, VSYNC_O} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_hs: hs=%b vs=%b, want hs=1 vs=1", HSYNC_O, VSYNC_O);
    end
`ifdef GA_CSYNC_EN
    checks++;
    if (CSYNC !== 1'b0) begin
      errors++;
      $display("FAIL csync_both: got %b want 0", CSYNC);
    end
`endif
    #2;
    nRESET = 1'b0;
    #1;
    checks++;
    if ({HSYNC_O, VSYNC_O, INT, MODE, LINE_CNT} !== 11'b0) begin
      errors++;
      $display("FAIL async_reset: hs=%b vs=%b int=%b mode=%0d cnt=%0d, want all 0", HSYNC_O, VSYNC_O, INT, MODE, LINE_CNT);
    end
`ifdef GA_CSYNC_EN
    checks++;
    if (CSYNC !== 1'b0) begin
      errors++;
      $display("FAIL csync_reset: got %b want 0", CSYNC);
    end
`endif
    @(negedge CLOCK);
    nRESET = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chr();
      checks++;
      if (HSYNC_O !== 1'b0) begin
        errors++;
        $display("FAIL no_hs_after_reset char %0d: got %b want 0", k, HSYNC_O);
      end
    end
    HSYNC_I = 1'b0;
    repeat (4) chr();
    for (int k = 0; k < 20; k++) hs_exp.push_back(k >= HS_DELAY && k < HS_DELAY + HS_MAX);
    drive_line(14);
    for (int k = 0; k < 20; k++) begin
      x = hs_exp.pop_front();
      o = hs_obs.pop_front();
      checks++;
      if (o !== x) begin
        errors++;
        $display("FAIL hs_after_reset char %0d: got %b want %b", k, o, x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lines();
    test_int_ack();
    test_vsync();
    test_mode();
    test_clr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
